// File: rtl/instruction_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instruction_prefetch_pkg
// Purpose : Shared types and constants for the instruction fetch stage.
//           fetch_entry_t pairs an instruction word with the PC it was
//           fetched from. POISON_INST marks an invalid instruction slot.
//           FETCH_ALIGN is the number of low address bits that are forced to
//           zero for fetch addresses.
// Rev     : 1.0  initial release
// ============================================================================
package instruction_prefetch_pkg;

    localparam int XLEN_PKG    = 32;
    localparam int FETCH_ALIGN = 2;

    localparam logic [XLEN_PKG-1:0] POISON_INST = 32'hc0defec4;

    typedef struct packed {
        logic [XLEN_PKG-1:0] inst;
        logic [XLEN_PKG-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instruction_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module  : instruction_prefetch_if
// Purpose : Bundles the fetch stage's instruction-memory port, redirect input
//           and decode-side output.
//   master : the fetch stage (drives requests and the decode outputs)
//   slave  : the environment (memory, redirect source, decode)
// Signals :
//   mem_req_addr/mem_req_en/mem_req_ready : fetch request handshake
//   mem_rsp_data/mem_rsp_valid            : in-order responses
//   override_pc/override_pc_addr          : redirect pulse and target
//   inst/inst_pc/valid/stall              : decode-side output
// Rev     : 1.0  initial release
// ============================================================================
interface instruction_prefetch_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_en;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_rsp_data;
    logic            mem_rsp_valid;
    logic            override_pc;
    logic [XLEN-1:0] override_pc_addr;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            valid;
    logic            stall;

    modport master (
        output mem_req_addr, mem_req_en, inst, inst_pc, valid,
        input  mem_req_ready, mem_rsp_data, mem_rsp_valid,
               override_pc, override_pc_addr, stall
    );

    modport slave (
        input  mem_req_addr, mem_req_en, inst, inst_pc, valid,
        output mem_req_ready, mem_rsp_data, mem_rsp_valid,
               override_pc, override_pc_addr, stall
    );
endinterface
`default_nettype wire

// File: rtl/instruction_prefetch_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : instruction_prefetch_sync_fifo
// Purpose : Generic synchronous FIFO of type T with DEPTH entries (power of
//           two). Simultaneous push and pop on a full FIFO is legal: the head
//           is read before the edge that overwrites its slot. flush empties
//           the FIFO and takes priority over push/pop.
// Ports   : clk, reset (sync, active-high), push, push_data, pop, flush,
//           head (current head entry), count, empty, full
// Rev     : 1.0  initial release
// ============================================================================
module instruction_prefetch_sync_fifo
    import instruction_prefetch_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 4
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    input  wire logic                         push,
    input  wire T                             push_data,
    input  wire logic                         pop,
    input  wire logic                         flush,
    output T                                  head,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              empty,
    output logic                              full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/instruction_prefetch.sv
`default_nettype none
// ============================================================================
// Module  : instruction_prefetch
// Purpose : Sequential instruction prefetcher. Keeps up to DEPTH requests in
//           flight against an in-order memory and buffers responses in a
//           DEPTH-entry queue presented to decode as {inst, inst_pc}. A PC
//           override flushes the queue and squashes responses still in
//           flight for the old path.
// Ports   : clk, reset (sync, active-high)
//           bus (master) : mem_req_* request port, mem_rsp_* response port,
//                          override_pc/override_pc_addr redirect,
//                          inst/inst_pc/valid output, stall from decode
// Note    : XLEN must match the width of fetch_entry_t fields (32).
// Rev     : 1.0  initial release
// ============================================================================
module instruction_prefetch
    import instruction_prefetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] POISON   = POISON_INST
) (
    input  wire logic               clk,
    input  wire logic               reset,
    instruction_prefetch_if.master  bus
);
    localparam int                CW        = $clog2(DEPTH+1);
    localparam logic [CW:0]       c_depth   = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0]   c_pc_step = XLEN'(4);
    localparam logic [CW-1:0]     c_one     = CW'(1);

    logic [XLEN-1:0] r_fetch_pc;     // address of the next request
    logic [XLEN-1:0] r_rsp_pc;       // PC of the next response that will be kept
    logic [CW-1:0]   r_outstanding;  // issued, not yet answered (includes squashed)
    logic [CW-1:0]   r_discard;      // in-flight responses belonging to a dead path

    logic [CW-1:0]   w_count;
    logic            w_empty;
    logic            w_full;
    fetch_entry_t    w_head;
    fetch_entry_t    w_entry;
    logic [CW:0]     w_inflight;
    logic            w_req_en;
    logic            w_req_fire;
    logic            w_rsp_drop;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_out_inc;
    logic [CW-1:0]   w_out_dec;
    logic [XLEN-1:0] w_target;

    // Credits: queue occupancy plus in-flight requests never exceed DEPTH, so
    // every response already has a reserved slot.
    assign w_inflight = {1'b0, w_count} + {1'b0, r_outstanding};
    assign w_req_en   = !reset && !bus.override_pc && (w_inflight < c_depth);
    assign w_req_fire = w_req_en && bus.mem_req_ready;

    // A response arriving in a redirect cycle belongs to the old path too.
    assign w_rsp_drop = bus.mem_rsp_valid && (bus.override_pc || (r_discard != '0));
    assign w_push     = bus.mem_rsp_valid && !w_rsp_drop && !reset;
    assign w_pop      = !w_empty && !bus.stall && !bus.override_pc && !reset;

    assign w_out_inc  = w_req_fire        ? c_one : '0;
    assign w_out_dec  = bus.mem_rsp_valid ? c_one : '0;
    assign w_target   = {bus.override_pc_addr[XLEN-1:FETCH_ALIGN], {FETCH_ALIGN{1'b0}}};

    always_comb begin
        w_entry      = '0;
        w_entry.inst = bus.mem_rsp_data;
        w_entry.pc   = r_rsp_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (bus.override_pc) begin
            // Everything still in flight after this cycle's response is stale.
            r_fetch_pc    <= w_target;
            r_rsp_pc      <= w_target;
            r_outstanding <= r_outstanding - w_out_dec;
            r_discard     <= r_outstanding - w_out_dec;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + c_pc_step;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + c_pc_step;
            end
            r_outstanding <= r_outstanding + w_out_inc - w_out_dec;
            if (w_rsp_drop) begin
                r_discard <= r_discard - c_one;
            end
        end
    end

    instruction_prefetch_sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_entry),
        .pop       (w_pop),
        .flush     (bus.override_pc),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_empty),
        .full      (w_full)
    );

    assign bus.mem_req_en   = w_req_en;
    assign bus.mem_req_addr = r_fetch_pc;
    assign bus.valid        = w_pop;
    assign bus.inst         = w_pop ? w_head.inst : POISON;
    assign bus.inst_pc      = w_empty ? r_fetch_pc : w_head.pc;

    a_count_bound : assert property (@(posedge clk) disable iff (reset)
        w_count <= CW'(DEPTH));
    a_credit      : assert property (@(posedge clk) disable iff (reset)
        w_inflight <= c_depth);
    a_discard     : assert property (@(posedge clk) disable iff (reset)
        r_discard <= r_outstanding);
    a_rsp_expect  : assert property (@(posedge clk) disable iff (reset)
        bus.mem_rsp_valid |-> (r_outstanding != '0));
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        w_push |-> (!w_full || w_pop));

endmodule
`default_nettype wire

// File: tb/tb_instruction_prefetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_prefetch
// Purpose : Self-checking bench. dut0 (RESET_PC=0) runs against an in-order
//           memory with configurable latency/readiness and a path/epoch
//           based expectation of the fetch and output streams. dut1
//           (RESET_PC=FFFFFFF8) covers address wrap and mid-burst reset.
// Rev     : 1.0  initial release
// ============================================================================
module tb_instruction_prefetch;
    import instruction_prefetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] POISON_V = 32'hc0defec4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;

    instruction_prefetch_if #(.XLEN(32)) bus0 ();
    instruction_prefetch_if #(.XLEN(32)) bus1 ();

    instruction_prefetch #(
        .XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000), .POISON(POISON_V)
    ) dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (bus0)
    );

    instruction_prefetch #(
        .XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .POISON(POISON_V)
    ) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- expectation state for dut0 ----------------
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        memq[$];      // requests accepted by memory, not yet answered
    int          cyc   = 0;
    int          epoch = 0;    // bumped on every redirect
    int          avail = 0;    // kept responses waiting for decode
    logic [31:0] req_pc;       // next address the fetcher must request
    logic [31:0] out_pc;       // next PC decode must see
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rand_ready = 1'b0;

    logic [31:0] req_log[$];
    logic [31:0] out_log[$];
    int          req_cyc[$];
    int          out_cyc[$];

    task automatic clear_logs();
        req_log.delete(); out_log.delete(); req_cyc.delete(); out_cyc.delete();
    endtask

    // One clock: compare at negedge, advance expectations at posedge,
    // drive memory-side inputs 1 time unit later.
    task automatic tick();
        logic        s_rst, s_ovr, s_stall, s_ready, s_rsp;
        logic [31:0] s_tgt;
        bit          exp_en, exp_valid;
        req_t        e;
        @(negedge clk);
        s_rst   = rst0;
        s_ovr   = bus0.override_pc;
        s_stall = bus0.stall;
        s_ready = bus0.mem_req_ready;
        s_rsp   = bus0.mem_rsp_valid;
        s_tgt   = bus0.override_pc_addr;
        exp_en    = !s_rst && !s_ovr && ((avail + memq.size()) < DEPTH);
        exp_valid = !s_rst && !s_ovr && !s_stall && (avail > 0);
        check("req_en", {31'b0, bus0.mem_req_en}, {31'b0, exp_en});
        check("valid", {31'b0, bus0.valid}, {31'b0, exp_valid});
        if (exp_en) check("req_addr", bus0.mem_req_addr, req_pc);
        if (exp_valid) begin
            check("inst_pc", bus0.inst_pc, out_pc);
            check("inst", bus0.inst, ~out_pc);
        end else begin
            check("inst_poison", bus0.inst, POISON_V);
        end
        if (!s_rst && avail == 0) check("empty_pc", bus0.inst_pc, req_pc);
        @(posedge clk);
        cyc++;
        if (s_rst) begin
            memq.delete();
            avail  = 0;
            req_pc = 32'h0;
            out_pc = 32'h0;
        end else begin
            if (s_rsp && memq.size() > 0) begin
                e = memq.pop_front();
                if (!s_ovr && e.epoch == epoch) avail++;
            end
            if (s_ovr) begin
                epoch++;
                avail  = 0;
                req_pc = {s_tgt[31:2], 2'b00};
                out_pc = req_pc;
            end else begin
                if (exp_en && s_ready) begin
                    e.addr  = req_pc;
                    e.epoch = epoch;
                    e.due   = cyc + $urandom_range(lat_min, lat_max) - 1;
                    memq.push_back(e);
                    req_log.push_back(req_pc);
                    req_cyc.push_back(cyc);
                    req_pc = req_pc + 32'd4;
                end
                if (exp_valid) begin
                    out_log.push_back(out_pc);
                    out_cyc.push_back(cyc);
                    avail--;
                    out_pc = out_pc + 32'd4;
                end
            end
        end
        #1;
        if (rand_ready) bus0.mem_req_ready = ($urandom_range(0, 1) == 1);
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            bus0.mem_rsp_valid = 1'b1;
            bus0.mem_rsp_data  = ~memq[0].addr;
        end else begin
            bus0.mem_rsp_valid = 1'b0;
            bus0.mem_rsp_data  = $urandom;
        end
    endtask

    initial begin
        bus0.mem_req_ready = 1'b1; bus0.mem_rsp_valid = 1'b0; bus0.mem_rsp_data = '0;
        bus0.override_pc = 1'b0; bus0.override_pc_addr = '0; bus0.stall = 1'b0;
        bus1.mem_req_ready = 1'b1; bus1.mem_rsp_valid = 1'b0; bus1.mem_rsp_data = '0;
        bus1.override_pc = 1'b0; bus1.override_pc_addr = '0; bus1.stall = 1'b0;
        rst0 = 1'b1; rst1 = 1'b1;
        req_pc = 32'h0; out_pc = 32'h0;

        // ---- dut1: wrap from FFFFFFF8 and reset in the middle of a burst ----
        repeat (2) @(posedge clk);
        #1 rst1 = 1'b0;
        @(negedge clk);
        check("wrap_en0",   {31'b0, bus1.mem_req_en}, 32'd1);
        check("wrap_addr0", bus1.mem_req_addr, 32'hFFFF_FFF8);
        @(posedge clk); @(negedge clk);
        check("wrap_addr1", bus1.mem_req_addr, 32'hFFFF_FFFC);
        @(posedge clk); @(negedge clk);
        check("wrap_addr2", bus1.mem_req_addr, 32'h0000_0000);
        @(posedge clk);
        #1 rst1 = 1'b1;
        @(negedge clk);
        check("rst_en",    {31'b0, bus1.mem_req_en}, 32'd0);
        check("rst_valid", {31'b0, bus1.valid}, 32'd0);
        check("rst_inst",  bus1.inst, POISON_V);
        @(posedge clk); @(negedge clk);
        check("rst_pc", bus1.inst_pc, 32'hFFFF_FFF8);
        @(posedge clk);
        #1 rst1 = 1'b0;
        @(negedge clk);
        check("rst_resume_addr", bus1.mem_req_addr, 32'hFFFF_FFF8);
        @(posedge clk);
        #1;

        // ---- dut0: reset state and sequential stream, latency 1 ----
        repeat (2) tick();
        rst0 = 1'b0;
        clear_logs();
        repeat (12) tick();
        check("seq_nreq", {31'b0, req_log.size() >= 3}, 32'd1);
        check("seq_nout", {31'b0, out_log.size() >= 1}, 32'd1);
        if (req_log.size() >= 3 && out_log.size() >= 1) begin
            check("seq_addr0", req_log[0], 32'h0);
            check("seq_addr1", req_log[1], 32'h4);
            check("seq_addr2", req_log[2], 32'h8);
            check("seq_first_pc", out_log[0], 32'h0);
            check("seq_latency", 32'(out_cyc[0] - req_cyc[0]), 32'd2);
        end

        // ---- stall: exactly DEPTH requests, then in-order drain ----
        bus0.stall = 1'b1;
        bus0.override_pc = 1'b1; bus0.override_pc_addr = 32'h200;
        tick();
        bus0.override_pc = 1'b0;
        clear_logs();
        repeat (10) tick();
        check("stall_nreq", 32'(req_log.size()), 32'd4);
        check("stall_en_low", {31'b0, bus0.mem_req_en}, 32'd0);
        bus0.stall = 1'b0;
        clear_logs();
        repeat (8) tick();
        check("drain_n", {31'b0, out_log.size() >= 4}, 32'd1);
        if (out_log.size() >= 4) begin
            check("drain_pc0", out_log[0], 32'h200);
            check("drain_pc1", out_log[1], 32'h204);
            check("drain_pc2", out_log[2], 32'h208);
            check("drain_pc3", out_log[3], 32'h20C);
        end

        // ---- redirect with requests in flight (latency 3), low bits ignored ----
        lat_min = 3; lat_max = 3;
        repeat (8) tick();
        check("inflight_3", {31'b0, memq.size() >= 3}, 32'd1);
        bus0.override_pc = 1'b1; bus0.override_pc_addr = 32'h107;
        clear_logs();
        tick();
        bus0.override_pc = 1'b0;
        repeat (10) tick();
        check("redir_n", {31'b0, (req_log.size() >= 1) && (out_log.size() >= 1)}, 32'd1);
        if (req_log.size() >= 1 && out_log.size() >= 1) begin
            check("redir_addr", req_log[0], 32'h104);
            check("redir_first_pc", out_log[0], 32'h104);
        end

        // ---- redirect in the same cycle as a response ----
        lat_min = 1; lat_max = 1;
        repeat (4) tick();
        for (int i = 0; i < 10 && !bus0.mem_rsp_valid; i++) tick();
        check("ovr_rsp_seen", {31'b0, bus0.mem_rsp_valid}, 32'd1);
        bus0.override_pc = 1'b1; bus0.override_pc_addr = 32'h300;
        #1;
        check("ovr_rsp_valid", {31'b0, bus0.valid}, 32'd0);
        clear_logs();
        tick();
        bus0.override_pc = 1'b0;
        repeat (6) tick();
        check("ovr_rsp_n", {31'b0, out_log.size() >= 1}, 32'd1);
        if (out_log.size() >= 1) check("ovr_rsp_first_pc", out_log[0], 32'h300);

        // ---- random readiness, latency 1-3, stalls, redirects, one reset ----
        rand_ready = 1'b1; lat_min = 1; lat_max = 3;
        clear_logs();
        for (int i = 0; i < 400; i++) begin
            bus0.stall = ($urandom_range(0, 3) == 0);
            bus0.override_pc = ($urandom_range(0, 39) == 0);
            bus0.override_pc_addr = $urandom;
            rst0 = (i == 200 || i == 201);
            tick();
        end
        bus0.override_pc = 1'b0; bus0.stall = 1'b0; rst0 = 1'b0;
        check("rand_progress", {31'b0, out_log.size() > 50}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
